fir_decimate: RTL and testbench
===============================

Name: fir_decimate

Overview:
- Sits directly downstream of the FIR low-pass filter.
- Consumes one filtered sample on each cycle where `ce` is high.
- Discards the filter warm-up samples at the start of each chirp, then keeps every DEC-th sample.
- Delivers exactly NSAMP samples per chirp to the FFT/USB path over a valid/ready handshake, with a small FIFO to absorb consumer stalls.

Parameters:
- IW, 14: width of the FIR output sample (two's complement).
- DEC, 20: decimation factor; keep 1 of every DEC accepted inputs.
- NDISCARD, 120: number of `ce` samples dropped after `frame_start` (FIR settling; at least the tap count).
- NSAMP, 1024: decimated samples emitted per frame.
- FIFO_DEPTH, 4: output buffer entries; must be a power of 2 and at least 2.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- ce, input, 1: input sample strobe, same enable that drives the FIR.
- frame_start, input, 1: single-cycle pulse marking chirp start.
- data_i, input, IW: FIR output, valid on cycles where `ce`=1.
- ready_i, input, 1: downstream can accept `data_o`.
- data_o, output, IW: decimated sample (head of FIFO).
- valid_o, output, 1: `data_o` is valid.
- idx_o, output, log2(NSAMP): index of the sample on `data_o` within the frame.
- last_o, output, 1: `data_o` is sample NSAMP-1 of the frame.
- overflow_o, output, 1: sticky; a kept sample was lost because the FIFO was full.
- busy_o, output, 1: frame in progress (state ≠ IDLE/DONE, or FIFO not empty).

Behaviour:
- Reset (`rst`=0, async):
  - state=IDLE; all counters 0; FIFO empty.
  - `data_o`=0, `valid_o`=0, `idx_o`=0, `last_o`=0, `overflow_o`=0, `busy_o`=0.
- States: IDLE, SETTLE, RUN, DONE.
  - IDLE/DONE: inputs are ignored. `frame_start` → SETTLE, which clears the discard counter, decimation counter, sample counter and `overflow_o`.
  - SETTLE: each `ce` increments the discard counter. The `ce` that brings the count to NDISCARD is dropped and moves the state to RUN. If NDISCARD=0, `frame_start` goes directly to RUN.
  - RUN: the decimation counter counts `ce` from 0 to DEC-1 and wraps. The sample at count 0 is kept, so the first sample after SETTLE is kept.
    - A kept sample is pushed into the FIFO with tag (sample counter, last = sample counter==NSAMP-1), then the sample counter increments.
    - After the push tagged NSAMP-1 the state moves to DONE. Exactly NSAMP pushes are attempted per frame, counting drops.
- `frame_start` in any non-IDLE state aborts the frame:
  - FIFO flushed the same cycle; `valid_o` goes 0 on the next cycle.
  - Counters and `overflow_o` cleared; state=SETTLE.
  - A `ce` on that same cycle is ignored.
- FIFO behaviour:
  - Show-ahead: `data_o`, `idx_o` and `last_o` are the head entry; `valid_o` = not empty.
  - Latency: a push into an empty FIFO at cycle N gives `valid_o`=1 at cycle N+1.
  - Pop happens when `valid_o` && `ready_i`.
  - Simultaneous push and pop: allowed at any occupancy, including full, with no overflow and occupancy unchanged.
  - Push while full without a pop: the sample is dropped and `overflow_o` is set.
    - The sample counter still advances, so indices skip and downstream can detect the gap.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- While `valid_o`=1 and `ready_i`=0, `data_o`, `idx_o` and `last_o` are held stable.
- `ce` outside RUN and SETTLE, or `ce` with `ready_i` changes, produce no state change except as stated above.
- Arithmetic: `data_i` is passed through unmodified (no rounding); counters are sized with clog2 of their limits.

Test Plan (DEC=4, NDISCARD=3, NSAMP=8, FIFO_DEPTH=4, `ready_i`=1 unless stated):
- Basic frame:
  - Stimulus: reset; `frame_start`; then `ce` every cycle with `data_i` = 0,1,2,...
  - Required: outputs are 3,7,11,...,31 with `idx_o`=0..7; `last_o` only on 31; then DONE and `busy_o`=0.
  - Later `ce` produces no output.
- Backpressure:
  - Stimulus: as basic frame, but `ready_i`=0 until 4 samples are buffered, then `ready_i`=1.
  - Required: samples 3,7,11,15 are held stable; no overflow; all 8 delivered in order.
- Overflow:
  - Stimulus: `ready_i`=0 for the whole frame.
  - Required: FIFO holds 3,7,11,15; the 5th kept sample (19) is dropped; `overflow_o`=1 on the cycle after that push.
  - Required: releasing `ready_i` delivers `idx_o` 0..3 only.
- Full plus simultaneous pop:
  - Stimulus: FIFO full; `ready_i`=1 on the same cycle as the next keep.
  - Required: no overflow; the sequence continues unbroken.
- Abort mid-frame:
  - Stimulus: `frame_start` after `idx_o`=2 has been emitted.
  - Required: `valid_o`=0 on the next cycle; the new frame restarts at `idx_o`=0 with data from input count 3 after the abort.
- Async reset mid-RUN:
  - Stimulus: deassert `rst` asynchronously mid-RUN.
  - Required: all outputs 0 immediately; the next `frame_start` behaves like the basic-frame case.

Source files
------------

// File: rtl/fir_decimate.sv
// fir_decimate: drops FIR warm-up samples after frame_start, keeps 1 of DEC,
// and emits NSAMP tagged samples per frame through a show-ahead FIFO.
// Ports: clk, rst (async active-low), ce/data_i (FIR samples),
// frame_start (chirp start / abort), ready_i (consumer), data_o/idx_o/last_o/
// valid_o (FIFO head), overflow_o (sticky drop flag), busy_o (frame active).
module fir_decimate #(
   parameter int IW         = 14,
   parameter int DEC        = 20,
   parameter int NDISCARD   = 120,
   parameter int NSAMP      = 1024,
   parameter int FIFO_DEPTH = 4,
   localparam int XW        = (NSAMP > 1) ? $clog2(NSAMP) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          frame_start,
   input  logic [IW-1:0] data_i,
   input  logic          ready_i,
   output logic [IW-1:0] data_o,
   output logic          valid_o,
   output logic [XW-1:0] idx_o,
   output logic          last_o,
   output logic          overflow_o,
   output logic          busy_o
);

   localparam int DW    = (NDISCARD > 1) ? $clog2(NDISCARD) : 1;
   localparam int CW    = (DEC > 1) ? $clog2(DEC) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = IW + XW + 1;
   localparam int DLAST = (NDISCARD > 0) ? NDISCARD - 1 : 0;
   localparam int CLAST = (DEC > 0) ? DEC - 1 : 0;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RUN,
      DONE
   } state_t;

   state_t          state;
   logic [DW-1:0]   disc_cnt;
   logic [CW-1:0]   dec_cnt;
   logic [XW-1:0]   smp_cnt;
   logic            overflow;

   // Extra MSB on each pointer tells full from empty.
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [EW-1:0]   head;

   logic empty;
   logic full;
   logic smp_last;
   logic keep;
   logic pop;
   logic push;
   logic drop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   assign smp_last = (smp_cnt == XW'(NSAMP - 1));

   // A frame_start cycle flushes and restarts, so its ce is not kept.
   assign keep = (state == RUN) && ce && !frame_start &&
                 (dec_cnt == '0);
   assign pop  = !empty && ready_i;
   // A full FIFO still accepts when the head leaves on the same edge.
   assign push = keep && (!full || pop);
   assign drop = keep && full && !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         disc_cnt <= '0;
         dec_cnt  <= '0;
         smp_cnt  <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else if (frame_start) begin
         state    <= (NDISCARD == 0) ? RUN : SETTLE;
         disc_cnt <= '0;
         dec_cnt  <= '0;
         smp_cnt  <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop) overflow <= 1'b1;
         unique case (state)
            SETTLE: begin
               if (ce) begin
                  if (disc_cnt == DW'(DLAST)) state <= RUN;
                  else disc_cnt <= disc_cnt + 1'b1;
               end
            end
            RUN: begin
               if (ce) begin
                  if (dec_cnt == CW'(CLAST)) dec_cnt <= '0;
                  else dec_cnt <= dec_cnt + 1'b1;
                  // Dropped samples still consume an index.
                  if (dec_cnt == '0) begin
                     smp_cnt <= smp_cnt + 1'b1;
                     if (smp_last) state <= DONE;
                  end
               end
            end
            IDLE: ;
            DONE: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {smp_last, smp_cnt, data_i};
   end

   // Head is masked while empty so outputs read 0 after reset or flush.
   always_comb begin
      data_o = '0;
      idx_o  = '0;
      last_o = 1'b0;
      if (!empty) begin
         data_o = head[IW-1:0];
         idx_o  = head[IW+XW-1:IW];
         last_o = head[EW-1];
      end
   end

   assign valid_o    = !empty;
   assign overflow_o = overflow;
   assign busy_o     = (state == SETTLE) || (state == RUN) || !empty;

endmodule

// File: tb/tb_fir_decimate.sv
// tb_fir_decimate: directed bench for fir_decimate with small parameters.
// Collects delivered samples at negedge and checks them against hand values.
module tb_fir_decimate;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic        frame_start = 1'b0;
   logic [13:0] data_i = '0;
   logic        ready_i = 1'b1;
   logic [13:0] data_o;
   logic        valid_o;
   logic [2:0]  idx_o;
   logic        last_o;
   logic        overflow_o;
   logic        busy_o;

   int total = 0;
   int bad = 0;
   int qd[$];
   int qi[$];
   int ql[$];

   fir_decimate #(
      .IW(14),
      .DEC(4),
      .NDISCARD(3),
      .NSAMP(8),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ce(ce),
      .frame_start(frame_start),
      .data_i(data_i),
      .ready_i(ready_i),
      .data_o(data_o),
      .valid_o(valid_o),
      .idx_o(idx_o),
      .last_o(last_o),
      .overflow_o(overflow_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst && valid_o && ready_i) begin
         qd.push_back(int'(data_o));
         qi.push_back(int'(idx_o));
         ql.push_back(int'(last_o));
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearq();
      qd.delete();
      qi.delete();
      ql.delete();
   endtask

   task automatic start();
      frame_start = 1'b1;
      ce = 1'b0;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic feed(input int n, input int base, input int rdy_on);
      for (int i = 0; i < n; i++) begin
         data_i = 14'(base + i);
         ce = 1'b1;
         ready_i = (i >= rdy_on);
         tick();
      end
      ce = 1'b0;
   endtask

   task automatic drain(input int n);
      ce = 1'b0;
      ready_i = 1'b1;
      repeat (n) tick();
   endtask

   task automatic check_q(input string tag, input int n, input int base);
      chk({tag, ".count"}, qd.size(), n);
      for (int k = 0; k < n && k < qd.size(); k++) begin
         chk({tag, ".data"}, qd[k], base + 3 + 4 * k);
         chk({tag, ".idx"}, qi[k], k);
         chk({tag, ".last"}, ql[k], (k == 7) ? 1 : 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // reset values
      tick();
      tick();
      chk("rst.valid", valid_o, 0);
      chk("rst.data", data_o, 0);
      chk("rst.idx", idx_o, 0);
      chk("rst.last", last_o, 0);
      chk("rst.ovf", overflow_o, 0);
      chk("rst.busy", busy_o, 0);
      rst = 1'b1;
      tick();

      // basic frame
      clearq();
      start();
      chk("basic.busy", busy_o, 1);
      feed(32, 0, 0);
      drain(6);
      check_q("basic", 8, 0);
      chk("basic.idle_busy", busy_o, 0);
      chk("basic.ovf", overflow_o, 0);
      feed(8, 200, 0);
      drain(4);
      chk("basic.after_done", qd.size(), 8);

      // backpressure
      clearq();
      start();
      for (int i = 0; i < 32; i++) begin
         data_i = 14'(i);
         ce = 1'b1;
         ready_i = (i >= 17);
         if (i == 8 || i == 17) begin
            chk("bp.hold_data", data_o, 3);
            chk("bp.hold_idx", idx_o, 0);
            chk("bp.hold_valid", valid_o, 1);
         end
         tick();
      end
      drain(6);
      check_q("bp", 8, 0);
      chk("bp.ovf", overflow_o, 0);

      // overflow
      clearq();
      start();
      for (int i = 0; i < 32; i++) begin
         data_i = 14'(i);
         ce = 1'b1;
         ready_i = 1'b0;
         tick();
         if (i == 18) chk("ovf.before", overflow_o, 0);
         if (i == 19) chk("ovf.set", overflow_o, 1);
      end
      drain(8);
      check_q("ovf", 4, 0);
      chk("ovf.sticky", overflow_o, 1);

      // full plus simultaneous pop
      clearq();
      start();
      for (int i = 0; i < 32; i++) begin
         data_i = 14'(i);
         ce = 1'b1;
         ready_i = (i >= 19);
         if (i == 19) chk("fullpop.full_head", idx_o, 0);
         tick();
      end
      drain(6);
      check_q("fullpop", 8, 0);
      chk("fullpop.ovf", overflow_o, 0);

      // abort mid-frame
      clearq();
      start();
      for (int i = 0; i < 16; i++) begin
         data_i = 14'(i);
         ce = 1'b1;
         ready_i = (i <= 12);
         tick();
      end
      chk("abort.emitted", qd.size(), 3);
      chk("abort.pending", valid_o, 1);
      frame_start = 1'b1;
      ce = 1'b1;
      data_i = 14'(99);
      ready_i = 1'b0;
      tick();
      frame_start = 1'b0;
      chk("abort.flush", valid_o, 0);
      chk("abort.busy", busy_o, 1);
      clearq();
      feed(32, 100, 0);
      drain(6);
      check_q("abort", 8, 100);

      // async reset mid-run
      clearq();
      start();
      for (int i = 0; i < 10; i++) begin
         data_i = 14'(i);
         ce = 1'b1;
         ready_i = 1'b0;
         tick();
      end
      chk("areset.pre_valid", valid_o, 1);
      #3;
      rst = 1'b0;
      #1;
      chk("areset.valid", valid_o, 0);
      chk("areset.data", data_o, 0);
      chk("areset.idx", idx_o, 0);
      chk("areset.last", last_o, 0);
      chk("areset.ovf", overflow_o, 0);
      chk("areset.busy", busy_o, 0);
      ce = 1'b0;
      ready_i = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      clearq();
      start();
      feed(32, 0, 0);
      drain(6);
      check_q("areset", 8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
